mem_sram_ctrl: RTL and testbench

Memory-stage responder for the EXE/MEM pipeline register: it accepts the registered memory request (read/write enables, ALU result as byte address, Rm value as store data) and serves it from an external 16-bit SRAM as two half-word accesses. While a request is in flight it drops `ready`, and the top level uses `ready` to freeze the upstream pipeline registers. Loaded words are returned on `read_data` toward the MEM/WB register.

---
 rtl/arm_mem_pkg.sv | 18 +
 rtl/sram_phase_counter.sv | 30 +++
 rtl/mem_sram_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory-stage SRAM responder: FSM state encoding
// and default address-map / SRAM geometry constants.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } mem_state_t;

   // Byte address that lands on SRAM half-word 0
   localparam int MEM_BASE_ADDR = 1024;
   // External SRAM geometry
   localparam int MEM_SRAM_AW   = 18;
   localparam int MEM_SRAM_DW   = 16;

endpackage

// File: rtl/sram_phase_counter.sv
// Per-phase wait counter for the SRAM controller. Counts 0..WAIT_CYCLES while
// enabled, wraps on its own at the end of a phase, and flags the last cycle.
module sram_phase_counter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_phase_last
);

   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   logic [CW-1:0] r_cnt;

   assign o_phase_last = (r_cnt == CW'(WAIT_CYCLES));

   // Phase counter: cleared outside an access, wraps to 0 when a phase ends
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_phase_last ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage responder: serves a 32-bit load/store from a 16-bit SRAM as a
// low half-word phase followed by a high half-word phase, holding ready low
// meanwhile so the pipeline freezes. All SRAM-facing outputs are registered.
// Optional build macro MEM_RANGE_CHECK_EN: reject out-of-map or misaligned
// requests with a one-cycle err pulse and no SRAM activity.
module mem_sram_ctrl
   import arm_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int BASE_ADDR   = MEM_BASE_ADDR,
   parameter int SRAM_AW     = MEM_SRAM_AW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic                   err,
   output logic [SRAM_AW-1:0]     sram_addr,
   output logic [MEM_SRAM_DW-1:0] sram_dq_o,
   output logic                   sram_dq_oe,
   input  logic [MEM_SRAM_DW-1:0] sram_dq_i,
   output logic                   sram_we_n
);

   mem_state_t             r_state;
   mem_state_t             w_next;
   logic                   w_req;
   logic                   w_fault;
   logic                   w_phase_last;
   logic                   w_cnt_clr;
   logic                   w_cnt_en;
   logic [31:0]            w_off;
   logic                   w_unused_off;
   logic                   r_is_wr;
   logic [MEM_SRAM_DW-1:0] r_wdata_hi;
   logic [MEM_SRAM_DW-1:0] r_shadow_lo;
   logic [31:0]            r_read_data;
   logic [SRAM_AW-1:0]     r_addr;
   logic [MEM_SRAM_DW-1:0] r_dq_o;
   logic                   r_oe;
   logic                   r_we_n;

   assign w_req        = wr_en | rd_en;
   assign w_off        = address - 32'(BASE_ADDR);
   // Bits outside the half-word map are intentionally dropped
   assign w_unused_off = ^{w_off[31:SRAM_AW+1], w_off[1:0]};

   assign ready      = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);
   assign read_data  = r_read_data;
   assign sram_addr  = r_addr;
   assign sram_dq_o  = r_dq_o;
   assign sram_dq_oe = r_oe;
   assign sram_we_n  = r_we_n;

`ifdef MEM_RANGE_CHECK_EN
   localparam logic [32:0] OFF_LIMIT = 33'(1) << (SRAM_AW + 1);
   logic r_err;

   assign w_fault = (address < 32'(BASE_ADDR)) || ({1'b0, w_off} >= OFF_LIMIT) ||
                    (address[1:0] != 2'b00);
   assign err     = r_err;

   // err is high only in the DONE cycle that follows a rejected request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_err <= 1'b0;
      else      r_err <= (r_state == ST_IDLE) && w_req && w_fault;
   end
`else
   assign w_fault = 1'b0;
   assign err     = 1'b0;
`endif

   sram_phase_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_phase_cnt (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_cnt_clr),
      .i_en         (w_cnt_en),
      .o_phase_last (w_phase_last)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // Next-state and counter control; write wins when both enables are high
   always_comb begin
      w_next    = r_state;
      w_cnt_clr = 1'b1;
      w_cnt_en  = 1'b0;
      case (r_state)
         ST_IDLE: if (w_req) w_next = w_fault ? ST_DONE : ST_LO;
         ST_LO: begin
            w_cnt_clr = 1'b0;
            w_cnt_en  = 1'b1;
            if (w_phase_last) w_next = ST_HI;
         end
         ST_HI: begin
            w_cnt_clr = 1'b0;
            w_cnt_en  = 1'b1;
            if (w_phase_last) w_next = ST_DONE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Request capture and low-half read shadow; only meaningful during an access
   always_ff @(posedge clk) begin
      if ((r_state == ST_IDLE) && w_req) begin
         r_is_wr    <= wr_en;
         r_wdata_hi <= write_data[31:16];
      end
      if ((r_state == ST_LO) && w_phase_last && !r_is_wr) r_shadow_lo <= sram_dq_i;
   end

   // SRAM pins and load result, updated on the edge that enters each phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_read_data <= '0;
         r_addr      <= '0;
         r_dq_o      <= '0;
         r_oe        <= 1'b0;
         r_we_n      <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req && !w_fault) begin
                  r_addr <= {w_off[SRAM_AW:2], 1'b0};
                  r_dq_o <= write_data[15:0];
                  r_we_n <= ~wr_en;
                  r_oe   <= wr_en;
               end
            end
            ST_LO: begin
               if (w_phase_last) begin
                  r_addr[0] <= 1'b1;
                  r_dq_o    <= r_wdata_hi;
               end
            end
            ST_HI: begin
               if (w_phase_last) begin
                  r_we_n <= 1'b1;
                  r_oe   <= 1'b0;
                  if (!r_is_wr) r_read_data <= {sram_dq_i, r_shadow_lo};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl (WAIT_CYCLES=1): table of directed
// accesses, hand sequences for back-to-back and mid-access reset, then random
// accesses checked against a word-level reference memory.
module tb_mem_sram_ctrl;

   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, rd_en;
   logic [31:0]   address, write_data, read_data;
   logic          ready, err;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_o, sram_dq_i;
   logic          sram_dq_oe, sram_we_n;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] sram_mem [0:(1<<AW)-1];
   logic [15:0] ref_mem [int];
   logic [31:0] last_rd;
   bit          q_ready [$];

   typedef struct {
      bit          wr;
      bit          rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_low;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   mem_sram_ctrl #(
      .WAIT_CYCLES (1),
      .BASE_ADDR   (1024),
      .SRAM_AW     (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .err        (err),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_i  (sram_dq_i),
      .sram_we_n  (sram_we_n)
   );

   // Combinational-read, clocked-write SRAM model
   assign sram_dq_i = sram_mem[sram_addr];
   always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_o;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (word-level view of the address map) --
   function automatic bit model_fault(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
      return (a < 32'd1024) || ((a - 32'd1024) >= (32'd1 << (AW + 1))) || (a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_hw(input logic [31:0] a);
      logic [31:0] word_idx;
      word_idx = ((a - 32'd1024) >> 2) & ((32'd1 << (AW - 1)) - 1);
      return int'(word_idx) * 2;
   endfunction

   function automatic logic [15:0] model_half(input int i);
      return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      return {model_half(model_hw(a) + 1), model_half(model_hw(a))};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] wd);
      ref_mem[model_hw(a)]     = wd[15:0];
      ref_mem[model_hw(a) + 1] = wd[31:16];
   endtask

   // One access from an IDLE cycle; returns positioned in the following IDLE cycle
   task automatic do_access(input string nm, input bit wr, input bit rd,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input bit exp_err, input int exp_low);
      int low, wel;
      bit done, err_seen;
      low = 0; wel = 0; done = 0; err_seen = 0;
      wr_en = wr; rd_en = rd; address = a; write_data = wd;
      #1;
      chk({nm, "_accept_ready"}, 32'(ready), 32'd0);
      q_ready.push_back(ready);
      for (int k = 0; k < 12 && !done; k++) begin
         @(posedge clk); #1;
         // inputs are scrambled after acceptance; they must be ignored
         wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
         #1;
         if (!sram_we_n) wel++;
         q_ready.push_back(ready);
         if (ready) begin
            done = 1'b1;
            err_seen = err;
         end else begin
            low++;
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: ready stayed 0 for 12 cycles, required to rise", nm);
      end
      chk({nm, "_low_cycles"}, 32'(low), 32'(exp_low));
      chk({nm, "_we_cycles"}, 32'(wel), (wr && exp_low > 0) ? 32'(exp_low) : 32'd0);
      chk({nm, "_err"}, 32'(err_seen), 32'(exp_err));
      chk({nm, "_read_data"}, read_data, exp_rd);
      @(posedge clk); #1;
      chk({nm, "_idle_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      bit          w, r, f;
      logic [31:0] a, wd, er;
      int          pat [12];

      for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
      last_rd = 32'h0;

      vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000, 1'b0, 4};
      vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 32'hDEADBEEF, 1'b0, 4};
      vecs[2] = '{1'b1, 1'b0, 32'd1032, 32'h12345678, 32'hDEADBEEF, 1'b0, 4};
      vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 32'h12345678, 1'b0, 4};
      vecs[4] = '{1'b1, 1'b1, 32'd1036, 32'hA5A5A5A5, 32'h12345678, 1'b0, 4};
`ifdef MEM_RANGE_CHECK_EN
      vecs[5] = '{1'b0, 1'b1, 32'd1000, 32'h00000000, 32'h12345678, 1'b1, 0};
`else
      vecs[5] = '{1'b0, 1'b1, 32'd1000, 32'h00000000, 32'h00000000, 1'b0, 4};
`endif
      vecs[6] = '{1'b0, 1'b1, 32'd1036, 32'h00000000, 32'hA5A5A5A5, 1'b0, 4};

      // Reset state
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 7; i++) begin
         if (i == 2) q_ready.delete();
         do_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_low);
         f = model_fault(vecs[i].addr);
         if (!f && vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata);
         else if (!f) last_rd = vecs[i].exp_rd;
         if (i == 0) begin
            chk("store_sram2", 32'(sram_mem[2]), 32'h0000BEEF);
            chk("store_sram3", 32'(sram_mem[3]), 32'h0000DEAD);
         end
         if (i == 1) begin
            for (int k = 0; k < 10; k++) begin
               chk($sformatf("hold_%0d", k), read_data, 32'hDEADBEEF);
               @(posedge clk); #1;
            end
         end
         if (i == 3) begin
            // store then load issued back to back from the accept cycle onward
            pat = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
            chk("b2b_len", 32'(q_ready.size()), 32'd12);
            for (int k = 0; k < 12 && k < q_ready.size(); k++)
               chk($sformatf("b2b_ready_%0d", k), 32'(q_ready[k]), 32'(pat[k]));
         end
         if (i == 4) begin
            chk("both_sram6", 32'(sram_mem[6]), 32'h0000A5A5);
            chk("both_sram7", 32'(sram_mem[7]), 32'h0000A5A5);
         end
      end

      // Reset in the second HI cycle of a load
      wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028; write_data = '0;
      @(posedge clk); #1; rd_en = 1'b0;         // LO cycle 1
      @(posedge clk); #1;                        // LO cycle 2
      @(posedge clk); #1;                        // HI cycle 1
      @(posedge clk); #1;                        // HI cycle 2
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_read_data", read_data, 32'd0);
      chk("midrst_we_n", 32'(sram_we_n), 32'd1);
      chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
      chk("midrst_addr", 32'(sram_addr), 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      do_access("after_rst", 1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 1'b0, 4);
      last_rd = 32'hDEADBEEF;

      // Random accesses against the reference model
      for (int i = 0; i < 40; i++) begin
         w  = 1'($urandom_range(0, 1));
         r  = w ? ($urandom_range(0, 3) == 0) : 1'b1;
`ifdef MEM_RANGE_CHECK_EN
         a  = 32'd1024 + 32'd4 * 32'($urandom_range(0, 31));
`else
         a  = 32'd1024 + 32'd4 * 32'($urandom_range(0, 31)) + 32'($urandom_range(0, 3));
`endif
         wd = $urandom;
         f  = model_fault(a);
         er = (w || f) ? last_rd : model_read(a);
         do_access($sformatf("rnd%0d", i), w, r, a, wd, er, f, f ? 0 : 4);
         if (!f && w) begin
            model_write(a, wd);
            chk($sformatf("rnd%0d_sram_lo", i), 32'(sram_mem[model_hw(a)]), 32'(wd[15:0]));
            chk($sformatf("rnd%0d_sram_hi", i), 32'(sram_mem[model_hw(a) + 1]), 32'(wd[31:16]));
         end else if (!f) begin
            last_rd = er;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
